// File: rtl/alu_pkg.sv
// Shared definitions for the ALU family: ALUop encoding, sequencer states
// and small op-classification helpers used by the serial ALU and its slice.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_supported_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  // SUB and SLT both run through the adder with B inverted and a carry seed of 1.
  function automatic logic is_sub_op(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: AND, OR or full-adder sum of one bit pair.
// Any operand inversion (B for subtract, result for NOR) lives in the sequencer.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [3:0] op,
  output logic       res,
  output logic       cout
);

  // Logic ops never produce a carry, so the sequencer's carry chain stays quiet.
  always_comb begin
    res  = 1'b0;
    cout = 1'b0;
    case (op)
      OP_AND:                 res = a & b;
      OP_OR, OP_NOR:          res = a | b;
      OP_ADD, OP_SUB, OP_SLT: begin
        res  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU: one W-bit operation computed LSB first through a single
// 1-bit slice, with operands and results exchanged over valid/ready ports.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int W  = 6,
  parameter int CW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   alu_op,
  input  logic         carry_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow,
  output logic         zero,
  output logic         op_err
);

  state_t         r_state;
  state_t         w_nextState;
  logic [W-1:0]   r_aShift;
  logic [W-1:0]   r_bShift;
  logic [W-1:0]   r_resShift;
  logic [3:0]     r_op;
  logic           r_carry;
  logic [CW-1:0]  r_cnt;
  logic           r_carryOut;
  logic           r_overflow;
  logic           r_zero;
  logic           r_opErr;

  logic           w_accept;
  logic           w_lastStep;
  logic           w_sliceRes;
  logic           w_sliceCout;
  logic           w_bit;
  logic           w_ovfRaw;
  logic           w_isAddSub;
  logic [W-1:0]   w_shifted;
  logic [W-1:0]   w_final;

  alu_bit_slice u_slice (
    .a    (r_aShift[0]),
    .b    (r_bShift[0]),
    .cin  (r_carry),
    .op   (r_op),
    .res  (w_sliceRes),
    .cout (w_sliceCout)
  );

  assign w_accept    = in_valid & in_ready;
  assign w_lastStep  = (r_state == S_RUN) && (r_cnt == CW'(W - 1));
  assign w_bit       = (r_op == OP_NOR) ? ~w_sliceRes : w_sliceRes;
  assign w_shifted   = {w_bit, r_resShift[W-1:1]};
  // On the MSB step r_carry is the carry into the MSB.
  assign w_ovfRaw    = r_carry ^ w_sliceCout;
  assign w_isAddSub  = (r_op == OP_ADD) || (r_op == OP_SUB);

  // SLT replaces the difference with its corrected sign bit; bad ops force zero.
  always_comb begin
    w_final = w_shifted;
    if (!is_supported_op(r_op)) begin
      w_final = '0;
    end else if (r_op == OP_SLT) begin
      w_final = {{(W-1){1'b0}}, w_sliceRes ^ w_ovfRaw};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = S_RUN;
      end
      S_RUN: begin
        if (w_lastStep) w_nextState = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, then shift one bit per RUN cycle; flags and
  // the final result are latched on the MSB step and held through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aShift   <= '0;
      r_bShift   <= '0;
      r_resShift <= '0;
      r_op       <= OP_AND;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_opErr    <= 1'b0;
    end else if (w_accept) begin
      r_aShift   <= a;
      r_bShift   <= is_sub_op(alu_op) ? ~b : b;
      r_resShift <= '0;
      r_op       <= alu_op;
      r_carry    <= is_sub_op(alu_op) ? 1'b1 : ((alu_op == OP_ADD) ? carry_in : 1'b0);
      r_cnt      <= '0;
      r_carryOut <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
      r_opErr    <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_aShift <= r_aShift >> 1;
      r_bShift <= r_bShift >> 1;
      r_carry  <= w_sliceCout;
      if (w_lastStep) begin
        r_cnt      <= '0;
        r_resShift <= w_final;
        r_carryOut <= w_sliceCout;
        r_overflow <= w_isAddSub ? w_ovfRaw : 1'b0;
        r_zero     <= (w_final == '0);
        r_opErr    <= !is_supported_op(r_op);
      end else begin
        r_cnt      <= r_cnt + CW'(1);
        r_resShift <= w_shifted;
      end
    end
  end

  assign result    = r_resShift;
  assign carry_out = r_carryOut;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign op_err    = r_opErr;

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial sequencer that computes a W-bit ALU operation one bit per clock through a single 1-bit ALU slice.
- It time-multiplexes the slice instead of rippling W copies, and feeds each cycle's carry-out back as the next cycle's carry-in.
- Operands arrive on a valid/ready request port; results, including carry, overflow and zero flags, leave on a valid/ready response port.
- It is the area-reduced counterpart of the combinational ripple ALU and shares its ALUop encoding.

Parameters:
- W, 6, operand/result width in bits (W >= 2).
- CW, 3, width of the bit-index counter; must satisfy 2**CW >= W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- a  input  W  operand A.
- b  input  W  operand B.
- alu_op  input  4  operation select.
- carry_in  input  1  LSB carry-in; used for ADD only.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  W  operation result.
- carry_out  output  1  carry out of the MSB.
- overflow  output  1  signed overflow (ADD/SUB only).
- zero  output  1  result == 0.
- op_err  output  1  alu_op was not a supported code.

Behaviour:
- Encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (signed)
  - 1100 NOR
  - Any other code: result 0, carry_out 0, overflow 0, zero 1, op_err 1. The code still takes the full W-cycle RUN.
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Outputs in reset:
  - in_ready = 1 while in IDLE.
  - out_valid, result, carry_out, overflow, zero and op_err are all 0.
  - Bit counter = 0.
- IDLE: when in_valid & in_ready, capture a, b, alu_op and carry_in into shift registers and go to RUN. in_ready is 1 only in IDLE.
- Carry seed at capture:
  - SUB and SLT: invert b and force the carry seed to 1; the carry_in port is ignored.
  - ADD: carry seed = carry_in.
  - Logic ops: carry seed = 0.
- RUN: one bit per cycle, LSB first.
  - Feed the slice with the LSBs of the A and B shift registers and the carry register.
  - Shift the slice result into the MSB of the result register.
  - Update the carry register with the slice carry-out.
  - Increment the counter.
  - After the cycle with counter == W-1, go to DONE.
- Flag capture on the W-1 step:
  - carry_out = final carry.
  - overflow = carry into MSB XOR carry out of MSB, for ADD/SUB only.
  - SLT: result = {W-1 zeros, sign of (a-b) XOR overflow}.
  - zero is computed from the final result.
- Latency: request accepted on cycle 0 gives out_valid = 1 on cycle W+1. With W=6 that is cycle 7.
- DONE: out_valid = 1; result and flags are held stable while out_ready = 0.
  - On out_valid & out_ready, go to IDLE and clear out_valid.
  - The next request may be accepted the cycle after the response handshake; there is no overlap and throughput is one op per W+2 cycles.
- Input changes while not in IDLE are ignored.
- A request held on in_valid across a reset is accepted on the first cycle after reset deasserts.
- rst asserted in any state, including mid-RUN or in DONE with out_ready low, returns to IDLE on the next edge.
  - The partial result is discarded and out_valid is forced to 0.
  - No response is produced for the aborted request.

Decomposition:
- Shared package alu_pkg holds:
  - The ALUop localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR).
  - The state encoding (S_IDLE, S_RUN, S_DONE).
  - An is_supported_op function.
- One sub-module: alu_bit_slice, a combinational 1-bit slice.
  - Inputs: a, b, cin, op[3:0].
  - Outputs: res, cout.
  - It computes AND/OR/sum and performs no inversion; inversion is done in the sequencer.

Test Plan:
- ADD: a=0x33, b=0x0F, carry_in=0, op=0010 -> result 0x02, carry_out 1, overflow 0, zero 0, out_valid on cycle 7.
- SUB and logic ops:
  - SUB a=0x33, b=0x0F, carry_in=0 (ignored) -> result 0x24, carry_out 1, overflow 0.
  - AND with the same operands -> 0x03.
  - NOR with the same operands -> 0x00, zero 1.
- SLT and overflow:
  - SLT a=0x0F, b=0x33 (15 vs -13) -> result 0x00.
  - SLT a=0x33, b=0x0F -> result 0x01.
  - ADD a=0x1F, b=0x01 -> result 0x20, overflow 1, carry_out 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - result and flags stay stable and in_ready stays 0.
  - On out_ready=1 for one cycle, out_valid drops next cycle and in_ready=1.
- Reset mid-RUN: assert rst for 1 cycle at counter=3 of an ADD.
  - Next cycle: IDLE, in_ready=1, out_valid=0.
  - A fresh ADD 0x01+0x01 then returns 0x02 with no stale bits.
- Unsupported op=1111 with a=0x3F, b=0x3F -> result 0x00, zero 1, op_err 1, carry_out 0, out_valid on cycle 7.
